// File: rtl/ir_nec_receiver.sv
// ir_nec_receiver: NEC infrared frame decoder with repeat detection and key-hold tracking.
//   clk          system clock, all state on rising edge
//   reset        asynchronous active-high reset
//   ir_in        raw demodulated IR input, active-low bursts, idle high
//   ir_code      last accepted 32-bit frame, bit 0 = first bit received
//   code_valid   one-cycle pulse when ir_code updates
//   repeat_valid one-cycle pulse on an accepted repeat frame while a key is held
//   key_held     high from an accepted frame until HOLD_US us pass without frame or repeat
//   frame_error  one-cycle pulse on a rejected or timed-out frame
module ir_nec_receiver #(
    parameter int US_DIV  = 50,
    parameter int HOLD_US = 120000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_in,
    output logic [31:0] ir_code,
    output logic        code_valid,
    output logic        repeat_valid,
    output logic        key_held,
    output logic        frame_error
);
    localparam int PW = US_DIV > 1 ? $clog2(US_DIV) : 1;
    localparam int HW = $clog2(HOLD_US + 1);
    typedef enum logic [2:0] {IDLE, LEAD_LO, LEAD_HI, BIT_LO, BIT_HI, STOP_LO} state_t;
    state_t        state;
    logic          ir_m, ir_s, ir_d;
    logic          rise, fall, us_tick, tmo, err, reload;
    logic          lead_ok, hdr_data, hdr_rpt, short_ok, long_ok;
    logic [PW-1:0] pre;
    logic [15:0]   dur;
    logic [4:0]    bitcnt;
    logic [31:0]   shreg;
    logic          rpt;
    logic [HW-1:0] hold;

    function automatic logic in_rng(input logic [15:0] v, input logic [15:0] lo, input logic [15:0] hi);
        return v >= lo && v <= hi;
    endfunction

    assign rise     = ir_s & ~ir_d;
    assign fall     = ~ir_s & ir_d;
    assign us_tick  = pre == PW'(US_DIV - 1);
    assign tmo      = dur >= 16'd12000;
    assign lead_ok  = in_rng(dur, 16'd8000, 16'd10000);
    assign hdr_data = in_rng(dur, 16'd4000, 16'd5000);
    assign hdr_rpt  = in_rng(dur, 16'd2000, 16'd2500);
    assign short_ok = in_rng(dur, 16'd400, 16'd700);
    assign long_ok  = in_rng(dur, 16'd1400, 16'd1900);
    // a repeat seen while no key is held is accepted silently and does not reload the timer
    assign reload   = state == STOP_LO && rise && short_ok && (!rpt || key_held);

    // phases strictly alternate, so each state only ever sees the one edge type it waits for;
    // an edge in the timeout cycle takes precedence over the timeout
    always_comb begin
        err = 1'b0;
        case (state)
            LEAD_LO: err = rise ? !lead_ok : tmo;
            LEAD_HI: err = fall ? !(hdr_data || hdr_rpt) : tmo;
            BIT_LO:  err = rise ? !short_ok : tmo;
            BIT_HI:  err = fall ? !(short_ok || long_ok) : tmo;
            STOP_LO: err = rise ? !short_ok : tmo;
            default: err = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {ir_m, ir_s, ir_d} <= 3'b111;
            pre <= '0;
            dur <= '0;
        end else begin
            {ir_d, ir_s, ir_m} <= {ir_s, ir_m, ir_in};
            pre <= us_tick ? '0 : pre + 1'b1;
            dur <= (rise || fall) ? '0 : (us_tick && dur != 16'hFFFF) ? dur + 1'b1 : dur;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bitcnt       <= '0;
            shreg        <= '0;
            rpt          <= 1'b0;
            hold         <= '0;
            ir_code      <= '0;
            code_valid   <= 1'b0;
            repeat_valid <= 1'b0;
            key_held     <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            code_valid   <= 1'b0;
            repeat_valid <= 1'b0;
            frame_error  <= 1'b0;
            if (reload) begin
                hold     <= '0;
                key_held <= 1'b1;
            end else if (key_held && us_tick) begin
                hold     <= hold == HW'(HOLD_US - 1) ? '0 : hold + 1'b1;
                key_held <= hold != HW'(HOLD_US - 1);
            end
            if (err) begin
                state       <= IDLE;
                frame_error <= 1'b1;
            end else begin
                case (state)
                    IDLE:    if (fall) state <= LEAD_LO;
                    LEAD_LO: if (rise) state <= LEAD_HI;
                    LEAD_HI: if (fall) begin
                        state  <= hdr_data ? BIT_LO : STOP_LO;
                        rpt    <= !hdr_data;
                        bitcnt <= '0;
                    end
                    BIT_LO:  if (rise) state <= BIT_HI;
                    BIT_HI:  if (fall) begin
                        shreg  <= {long_ok, shreg[31:1]};
                        bitcnt <= bitcnt + 1'b1;
                        state  <= bitcnt == 5'd31 ? STOP_LO : BIT_LO;
                    end
                    STOP_LO: if (rise) begin
                        state        <= IDLE;
                        ir_code      <= rpt ? ir_code : shreg;
                        code_valid   <= !rpt;
                        repeat_valid <= rpt && key_held;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
